// File: rtl/awb_gain_ctrl.sv
// Auto-white-balance controller: accumulates per-channel sums over a frame, then during
// vertical blanking divides them sequentially to derive red/blue gains relative to green.
module awb_gain_ctrl #(
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned GREEN_GAIN = 7,
  parameter int unsigned RED_INIT   = 10,
  parameter int unsigned BLUE_INIT  = 9,
  parameter int unsigned GAIN_MIN   = 4,
  parameter int unsigned GAIN_MAX   = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awb_enable,
  input  logic        input_vsync,
  input  logic        input_den,
  input  logic [29:0] input_data_even,
  input  logic [29:0] input_data_odd,
  output logic [3:0]  red_gain,
  output logic [3:0]  green_gain,
  output logic [3:0]  blue_gain,
  output logic        gain_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned PIX_W  = 10;
  localparam int unsigned GAIN_W = 4;
  localparam int unsigned NUM_W  = ACC_W + 4;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned CNT_W  = 3;

  localparam logic [GAIN_W-1:0] G_GREEN = GAIN_W'(GREEN_GAIN);
  localparam logic [GAIN_W-1:0] G_RED0  = GAIN_W'(RED_INIT);
  localparam logic [GAIN_W-1:0] G_BLUE0 = GAIN_W'(BLUE_INIT);
  localparam logic [GAIN_W-1:0] G_MIN   = GAIN_W'(GAIN_MIN);
  localparam logic [GAIN_W-1:0] G_MAX   = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0] G_SAT   = '1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DIV_R,
    ST_DIV_B,
    ST_UPDATE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_vsync_d;
  logic [ACC_W-1:0]   r_sum_r, r_sum_g, r_sum_b;
  logic [ACC_W-1:0]   w_sum_r_nxt, w_sum_g_nxt, w_sum_b_nxt;
  logic [ACC_W-1:0]   r_sb, w_sb_nxt;
  logic [NUM_W-1:0]   r_num, w_num_nxt;
  logic [NUM_W-1:0]   r_den, w_den_nxt;
  logic [NUM_W-1:0]   r_rem, w_rem_nxt;
  logic [NUM_W-1:0]   w_shift;
  logic [GAIN_W-1:0]  r_q, w_q_nxt;
  logic [GAIN_W-1:0]  r_qr, w_qr_nxt;
  logic               r_hold, w_hold_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   w_bit;
  logic               r_pend, w_pend_nxt;
  logic [GAIN_W-1:0]  r_red_gain, w_red_nxt;
  logic [GAIN_W-1:0]  r_blue_gain, w_blue_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_overrun, w_overrun_nxt;
  logic               w_rise, w_fall, w_busy_st;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] s,
                                               input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    logic [SUM_W-1:0] t;
    t = {1'b0, s} + SUM_W'(a) + SUM_W'(b);
    return t[ACC_W] ? '1 : t[ACC_W-1:0];
  endfunction

  function automatic logic [GAIN_W-1:0] clamp_gain(input logic [GAIN_W-1:0] q);
    if (q < G_MIN) return G_MIN;
    if (q > G_MAX) return G_MAX;
    return q;
  endfunction

  assign w_rise    = input_vsync & ~r_vsync_d;
  assign w_fall    = ~input_vsync & r_vsync_d;
  assign w_busy_st = (r_state == ST_DIV_R) || (r_state == ST_DIV_B) || (r_state == ST_UPDATE);
  assign w_bit     = CNT_LAST - r_cnt;
  assign w_shift   = r_den << w_bit;

  // Frame accumulation runs regardless of the FSM; division works from the snapshot.
  always_comb begin
    w_sum_r_nxt = r_sum_r;
    w_sum_g_nxt = r_sum_g;
    w_sum_b_nxt = r_sum_b;
    if (w_fall) begin
      w_sum_r_nxt = '0;
      w_sum_g_nxt = '0;
      w_sum_b_nxt = '0;
    end else if (input_den) begin
      w_sum_r_nxt = sat_add(r_sum_r, input_data_even[29:20], input_data_odd[29:20]);
      w_sum_g_nxt = sat_add(r_sum_g, input_data_even[19:10], input_data_odd[19:10]);
      w_sum_b_nxt = sat_add(r_sum_b, input_data_even[9:0],   input_data_odd[9:0]);
    end
  end

  // Next-state and divider datapath.
  always_comb begin
    w_state_nxt   = r_state;
    w_num_nxt     = r_num;
    w_den_nxt     = r_den;
    w_rem_nxt     = r_rem;
    w_q_nxt       = r_q;
    w_qr_nxt      = r_qr;
    w_sb_nxt      = r_sb;
    w_hold_nxt    = r_hold;
    w_cnt_nxt     = r_cnt;
    w_pend_nxt    = r_pend;
    w_red_nxt     = r_red_gain;
    w_blue_nxt    = r_blue_gain;
    w_valid_nxt   = 1'b0;
    w_overrun_nxt = r_overrun | (w_rise & w_busy_st);

    case (r_state)
      ST_IDLE: begin
        if (w_fall) w_state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (w_rise) begin
          if (awb_enable && (r_sum_g != '0)) begin
            w_state_nxt = ST_DIV_R;
            w_num_nxt   = NUM_W'(r_sum_g) * NUM_W'(GREEN_GAIN);
            w_den_nxt   = NUM_W'(r_sum_r);
            w_sb_nxt    = r_sum_b;
            w_cnt_nxt   = '0;
            w_pend_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DIV_R, ST_DIV_B: begin
        if (w_fall) w_pend_nxt = 1'b1;
        if (r_cnt == '0) begin
          if (r_den == '0) begin
            w_hold_nxt = 1'b1;
            w_q_nxt    = (r_state == ST_DIV_R) ? r_red_gain : r_blue_gain;
          end else if (r_num >= (r_den << 4)) begin
            w_hold_nxt = 1'b1;
            w_q_nxt    = G_SAT;
          end else begin
            w_hold_nxt = 1'b0;
            w_rem_nxt  = r_num;
            w_q_nxt    = '0;
          end
        end else if (!r_hold && (r_rem >= w_shift)) begin
          w_rem_nxt = r_rem - w_shift;
          w_q_nxt   = r_q | (GAIN_W'(1) << w_bit);
        end
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (r_state == ST_DIV_R) begin
            w_qr_nxt    = w_q_nxt;
            w_den_nxt   = NUM_W'(r_sb);
            w_state_nxt = ST_DIV_B;
          end else begin
            w_state_nxt = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        w_red_nxt   = clamp_gain(r_qr);
        w_blue_nxt  = clamp_gain(r_q);
        w_valid_nxt = 1'b1;
        w_pend_nxt  = 1'b0;
        w_state_nxt = (w_fall || r_pend) ? ST_ACCUM : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt == ST_DIV_R) || (w_state_nxt == ST_DIV_B) ||
                 (w_state_nxt == ST_UPDATE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_vsync_d   <= 1'b1;
      r_sum_r     <= '0;
      r_sum_g     <= '0;
      r_sum_b     <= '0;
      r_sb        <= '0;
      r_num       <= '0;
      r_den       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_qr        <= '0;
      r_hold      <= 1'b0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_red_gain  <= G_RED0;
      r_blue_gain <= G_BLUE0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_vsync_d   <= input_vsync;
      r_sum_r     <= w_sum_r_nxt;
      r_sum_g     <= w_sum_g_nxt;
      r_sum_b     <= w_sum_b_nxt;
      r_sb        <= w_sb_nxt;
      r_num       <= w_num_nxt;
      r_den       <= w_den_nxt;
      r_rem       <= w_rem_nxt;
      r_q         <= w_q_nxt;
      r_qr        <= w_qr_nxt;
      r_hold      <= w_hold_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend      <= w_pend_nxt;
      r_red_gain  <= w_red_nxt;
      r_blue_gain <= w_blue_nxt;
      r_valid     <= w_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign red_gain   = r_red_gain;
  assign green_gain = G_GREEN;
  assign blue_gain  = r_blue_gain;
  assign gain_valid = r_valid;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_awb_gain_ctrl.sv
// Bench for awb_gain_ctrl: a frame-level reference model (sums, integer divide, clamp,
// fixed 11-edge latency window) is compared against the DUT outputs every cycle.
module tb_awb_gain_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        awb_enable = 1'b1;
  logic        input_vsync = 1'b1;
  logic        input_den = 1'b0;
  logic [29:0] input_data_even = '0;
  logic [29:0] input_data_odd = '0;
  logic [3:0]  red_gain, green_gain, blue_gain;
  logic        gain_valid, busy, overrun;

  awb_gain_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .awb_enable      (awb_enable),
    .input_vsync     (input_vsync),
    .input_den       (input_den),
    .input_data_even (input_data_even),
    .input_data_odd  (input_data_odd),
    .red_gain        (red_gain),
    .green_gain      (green_gain),
    .blue_gain       (blue_gain),
    .gain_valid      (gain_valid),
    .busy            (busy),
    .overrun         (overrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gain from frame sums: floor(G*7/d), capped at 15, clamped to [4,15]; d==0 holds.
  function automatic int ref_gain(input longint num, input longint d, input int cur);
    longint q;
    if (d == 0) return cur;
    q = num / d;
    if (q > 15) q = 15;
    if (q < 4) q = 4;
    return int'(q);
  endfunction

  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  longint m_sr = 0, m_sg = 0, m_sb = 0;
  longint m_k = 0, m_upd = -1;
  bit     m_pv = 1'b1, m_armed = 1'b0;
  bit     m_rise, m_fall, m_busy_now;
  int     m_qr = 0, m_qb = 0;
  int     exp_red = 10, exp_blue = 9;
  bit     exp_valid = 1'b0, exp_busy = 1'b0, exp_ovr = 1'b0;

  // Reference model: a frame ends at a rise; an accepted frame is busy for edges
  // t0..t0+10 and its gains land at edge t0+11.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_sr = 0; m_sg = 0; m_sb = 0;
      m_upd = -1; m_pv = 1'b1; m_armed = 1'b0;
      exp_red = 10; exp_blue = 9;
      exp_valid = 1'b0; exp_busy = 1'b0; exp_ovr = 1'b0;
    end else begin
      m_k++;
      m_rise     = input_vsync && !m_pv;
      m_fall     = !input_vsync && m_pv;
      m_busy_now = (m_upd >= 0) && (m_k <= m_upd);
      exp_valid  = 1'b0;
      if ((m_upd >= 0) && (m_k == m_upd)) begin
        exp_red = m_qr; exp_blue = m_qb; exp_valid = 1'b1;
      end
      if (m_rise) begin
        if (m_busy_now) exp_ovr = 1'b1;
        else if (m_armed) begin
          m_armed = 1'b0;
          if (awb_enable && m_sg != 0) begin
            m_upd = m_k + 11;
            m_qr  = ref_gain(m_sg * 7, m_sr, exp_red);
            m_qb  = ref_gain(m_sg * 7, m_sb, exp_blue);
          end
        end
      end
      if (m_fall) begin
        m_armed = 1'b1;
        m_sr = 0; m_sg = 0; m_sb = 0;
      end else if (input_den) begin
        m_sr += longint'(input_data_even[29:20]) + longint'(input_data_odd[29:20]);
        m_sg += longint'(input_data_even[19:10]) + longint'(input_data_odd[19:10]);
        m_sb += longint'(input_data_even[9:0])   + longint'(input_data_odd[9:0]);
        if (m_sr > SAT) m_sr = SAT;
        if (m_sg > SAT) m_sg = SAT;
        if (m_sb > SAT) m_sb = SAT;
      end
      exp_busy = (m_upd >= 0) && (m_k < m_upd);
      m_pv = input_vsync;
    end
  end

  always @(negedge clock) begin
    chk("red_gain",   red_gain,   exp_red);
    chk("blue_gain",  blue_gain,  exp_blue);
    chk("green_gain", green_gain, 7);
    chk("gain_valid", gain_valid, exp_valid);
    chk("busy",       busy,       exp_busy);
    chk("overrun",    overrun,    exp_ovr);
    if (gain_valid) n_valid++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [9:0] pix(input int base, input bit rnd);
    if (base == 0 || !rnd) return 10'(base);
    return 10'(base ^ int'($urandom_range(0, 15)));
  endfunction

  // One frame: fall, 4 lines x 4 pixel pairs, then vsync raised (rise sampled next edge).
  task automatic frame(input int r, input int g, input int b, input bit rnd);
    input_vsync = 1'b0;
    tick();
    repeat (2) tick();
    for (int ln = 0; ln < 4; ln++) begin
      for (int p = 0; p < 4; p++) begin
        if (rnd && $urandom_range(0, 3) == 0) begin
          input_den = 1'b0;
          tick();
        end
        input_den       = 1'b1;
        input_data_even = {pix(r, rnd), pix(g, rnd), pix(b, rnd)};
        input_data_odd  = {pix(r, rnd), pix(g, rnd), pix(b, rnd)};
        tick();
      end
      input_den = 1'b0;
      input_data_even = '0;
      input_data_odd  = '0;
      repeat (2) tick();
    end
    input_vsync = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int nv0;
    int r, g, b, n;

    chk("pin_equal",   ref_gain(7 * 16384, 16384, 10), 7);
    chk("pin_double",  ref_gain(7 * 16384, 8192, 10), 14);
    chk("pin_clamp",   ref_gain(7 * 16384, 32736, 9), 4);
    chk("pin_sat",     ref_gain(7 * 16384, 4096, 10), 15);
    chk("pin_hold",    ref_gain(7 * 600, 0, 10), 10);

    repeat (3) tick();
    chk("rst_red", red_gain, 10);
    chk("rst_blue", blue_gain, 9);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    repeat (3) tick();

    // Equal channels, explicit E10/E11 latency.
    nv0 = n_valid;
    frame(512, 512, 512, 1'b0);
    @(posedge clock);
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("lat_e10_valid", gain_valid, 0);
    chk("lat_e10_busy", busy, 1);
    @(posedge clock);
    @(negedge clock);
    chk("lat_e11_valid", gain_valid, 1);
    chk("t1_red", red_gain, 7);
    chk("t1_blue", blue_gain, 7);
    repeat (4) tick();
    chk("t1_pulses", n_valid - nv0, 1);

    frame(256, 512, 1023, 1'b0);
    repeat (14) tick();
    chk("t2_red", red_gain, 14);
    chk("t2_blue", blue_gain, 4);

    frame(128, 512, 512, 1'b0);
    repeat (14) tick();
    chk("t3_red", red_gain, 15);
    chk("t3_blue", blue_gain, 7);

    // Disabled frame and green-less frame leave gains alone.
    nv0 = n_valid;
    awb_enable = 1'b0;
    frame(100, 500, 100, 1'b0);
    repeat (14) tick();
    awb_enable = 1'b1;
    frame(300, 0, 300, 1'b0);
    repeat (14) tick();
    chk("t5_nopulse", n_valid - nv0, 0);
    chk("t5_red", red_gain, 15);
    chk("t5_blue", blue_gain, 7);

    // Extra vsync pulse during DIV_R.
    nv0 = n_valid;
    frame(300, 500, 400, 1'b0);
    tick();
    tick();
    input_vsync = 1'b0;
    tick();
    input_vsync = 1'b1;
    repeat (14) tick();
    chk("t5_overrun", overrun, 1);
    chk("t5_red_ovr", red_gain, 11);
    chk("t5_blue_ovr", blue_gain, 8);
    chk("t5_ovr_pulse", n_valid - nv0, 1);

    // Reset in the middle of DIV_R.
    frame(256, 512, 512, 1'b0);
    repeat (4) tick();
    nv0 = n_valid;
    reset = 1'b1;
    #1;
    chk("t6_red", red_gain, 10);
    chk("t6_blue", blue_gain, 9);
    chk("t6_busy", busy, 0);
    chk("t6_ovr", overrun, 0);
    tick();
    reset = 1'b0;
    repeat (14) tick();
    chk("t6_nopulse", n_valid - nv0, 0);

    // Zero red sum holds red gain at its reset value.
    frame(0, 600, 600, 1'b0);
    repeat (14) tick();
    chk("t4_red", red_gain, 10);
    chk("t4_blue", blue_gain, 7);

    for (int f = 0; f < 25; f++) begin
      r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 1023));
      g = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 1023));
      b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 1023));
      awb_enable = ($urandom_range(0, 9) != 0);
      frame(r, g, b, 1'b1);
      n = int'($urandom_range(3, 20));
      repeat (2) tick();
      awb_enable = ($urandom_range(0, 9) != 0);
      repeat (n - 2) tick();
      if ($urandom_range(0, 7) == 0) begin
        input_vsync = 1'b0;
        tick();
        input_vsync = 1'b1;
        tick();
      end
    end
    repeat (16) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
